// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle FETCH/EXEC/MEM control unit with memory timeout and illegal-opcode trap
module cpu_control_fsm #(
    parameter int DATA_WIDTH  = 16,
    parameter int PC_WIDTH    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           INS,
    input  logic [4:0]            PSR,
    input  logic                  MemReady,
    output logic [3:0]            OpCode,
    output logic [3:0]            OpExt,
    output logic                  RegWrite,
    output logic [3:0]            RegIn,
    output logic [3:0]            RegA,
    output logic [3:0]            RegB,
    output logic [DATA_WIDTH-1:0] Immediate,
    output logic [PC_WIDTH-1:0]   PCImmediate,
    output logic [1:0]            SelALU,
    output logic                  SelMEM,
    output logic                  MemReq,
    output logic                  MemRW,
    output logic                  IRWrite,
    output logic                  PCIncrement,
    output logic                  PCBranch,
    output logic                  PCWrite,
    output logic                  PSRWrite,
    output logic                  Fault
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_FAULT} state_t;

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       fault_q, fault_set, wait_hit;
    logic       unused_flag;

    logic [3:0] op, ext, rd, rs;
    logic [7:0] imm8;

    assign op          = INS[15:12];
    assign rd          = INS[11:8];
    assign ext         = INS[7:4];
    assign rs          = INS[3:0];
    assign imm8        = INS[7:0];
    assign unused_flag = PSR[2];
    assign wait_hit    = (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign Fault       = fault_q;

    // PSR = {N,Z,F,L,C}
    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] psr);
        case (c)
            4'b0000: cond_true = psr[3];
            4'b0001: cond_true = !psr[3];
            4'b0010: cond_true = psr[0];
            4'b0011: cond_true = !psr[0];
            4'b0100: cond_true = psr[1];
            4'b0101: cond_true = !psr[1];
            4'b0110: cond_true = psr[4];
            4'b0111: cond_true = !psr[4];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    always_comb begin
        next_state  = state;
        fault_set   = 1'b0;
        OpCode      = '0;
        OpExt       = '0;
        RegWrite    = 1'b0;
        RegIn       = '0;
        RegA        = '0;
        RegB        = '0;
        Immediate   = '0;
        PCImmediate = '0;
        SelALU      = 2'b00;
        SelMEM      = 1'b0;
        MemReq      = 1'b0;
        MemRW       = 1'b0;
        IRWrite     = 1'b0;
        PCIncrement = 1'b0;
        PCBranch    = 1'b0;
        PCWrite     = 1'b0;
        PSRWrite    = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq = 1'b1;
                SelMEM = 1'b1;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    next_state = S_EXEC;
                end else if (wait_hit) begin
                    fault_set  = 1'b1;
                    next_state = S_FAULT;
                end
            end
            S_EXEC: begin
                OpCode      = op;
                OpExt       = ext;
                next_state  = S_FETCH;
                PCIncrement = 1'b1;
                case (op)
                    4'b0000: begin
                        RegA     = rd;
                        RegB     = rs;
                        SelALU   = 2'b01;
                        RegWrite = (ext != 4'b1011);
                        RegIn    = rd;
                        PSRWrite = 1'b1;
                    end
                    4'b0101, 4'b1001, 4'b1011: begin
                        Immediate = {{(DATA_WIDTH-8){imm8[7]}}, imm8};
                        RegA      = rd;
                        RegWrite  = (op != 4'b1011);
                        RegIn     = rd;
                        PSRWrite  = 1'b1;
                    end
                    4'b0110, 4'b1101: begin
                        Immediate = {{(DATA_WIDTH-8){1'b0}}, imm8};
                        RegA      = rd;
                        RegWrite  = 1'b1;
                        RegIn     = rd;
                        PSRWrite  = (op == 4'b0110);
                    end
                    4'b1111: begin
                        Immediate = {imm8, {(DATA_WIDTH-8){1'b0}}};
                        RegA      = rd;
                        RegWrite  = 1'b1;
                        RegIn     = rd;
                    end
                    4'b0100: begin
                        if (ext == 4'b0000 || ext == 4'b0100) begin
                            PCIncrement = 1'b0;
                            next_state  = S_MEM;
                        end else if (ext == 4'b1100) begin
                            RegB = rs;
                            if (cond_true(rd, PSR)) begin
                                PCWrite     = 1'b1;
                                PCIncrement = 1'b0;
                            end
                        end else begin
                            PCIncrement = 1'b0;
                            fault_set   = 1'b1;
                            next_state  = S_FAULT;
                        end
                    end
                    4'b1100: begin
                        PCImmediate = {{(PC_WIDTH-8){imm8[7]}}, imm8};
                        if (cond_true(rd, PSR)) begin
                            PCBranch    = 1'b1;
                            PCIncrement = 1'b0;
                        end
                    end
                    default: begin
                        PCIncrement = 1'b0;
                        fault_set   = 1'b1;
                        next_state  = S_FAULT;
                    end
                endcase
            end
            S_MEM: begin
                MemReq = 1'b1;
                RegB   = rs;
                MemRW  = (ext == 4'b0100);
                if (MemRW)
                    RegA = rd;
                if (MemReady) begin
                    PCIncrement = 1'b1;
                    next_state  = S_FETCH;
                    if (!MemRW) begin
                        RegWrite = 1'b1;
                        RegIn    = rd;
                        SelALU   = 2'b10;
                    end
                end else if (wait_hit) begin
                    fault_set  = 1'b1;
                    next_state = S_FAULT;
                end
            end
            default: ;
        endcase
        // Holding reset low silences every request, even mid-transaction.
        if (!Reset) begin
            next_state  = S_FETCH;
            fault_set   = 1'b0;
            OpCode      = '0;
            OpExt       = '0;
            RegWrite    = 1'b0;
            RegIn       = '0;
            RegA        = '0;
            RegB        = '0;
            Immediate   = '0;
            PCImmediate = '0;
            SelALU      = 2'b00;
            SelMEM      = 1'b0;
            MemReq      = 1'b0;
            MemRW       = 1'b0;
            IRWrite     = 1'b0;
            PCIncrement = 1'b0;
            PCBranch    = 1'b0;
            PCWrite     = 1'b0;
            PSRWrite    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (fault_set)
                fault_q <= 1'b1;
            if (next_state != state)
                wait_cnt <= '0;
            else if (MemReq && !MemReady)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed-vector bench for cpu_control_fsm
module tb_cpu_control_fsm;

    logic        Clock, Reset, MemReady;
    logic [15:0] INS;
    logic [4:0]  PSR;
    logic [3:0]  OpCode, OpExt, RegIn, RegA, RegB;
    logic        RegWrite, SelMEM, MemReq, MemRW, IRWrite;
    logic        PCIncrement, PCBranch, PCWrite, PSRWrite, Fault;
    logic [15:0] Immediate, PCImmediate;
    logic [1:0]  SelALU;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_control_fsm dut (
        .Clock(Clock), .Reset(Reset), .INS(INS), .PSR(PSR), .MemReady(MemReady),
        .OpCode(OpCode), .OpExt(OpExt), .RegWrite(RegWrite), .RegIn(RegIn),
        .RegA(RegA), .RegB(RegB), .Immediate(Immediate), .PCImmediate(PCImmediate),
        .SelALU(SelALU), .SelMEM(SelMEM), .MemReq(MemReq), .MemRW(MemRW),
        .IRWrite(IRWrite), .PCIncrement(PCIncrement), .PCBranch(PCBranch),
        .PCWrite(PCWrite), .PSRWrite(PSRWrite), .Fault(Fault)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // From FETCH: present an instruction with a ready memory and step into EXEC.
    task automatic do_fetch(input logic [15:0] ins);
        INS      = ins;
        MemReady = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; INS = '0; PSR = '0; MemReady = 1'b0;
        tick(); tick(); #1;
        check("rst_memreq", 32'(MemReq), 0);
        check("rst_fault",  32'(Fault), 0);
        check("rst_irw",    32'(IRWrite), 0);
        check("rst_pcinc",  32'(PCIncrement), 0);

        Reset = 1'b1; INS = 16'h53FF; MemReady = 1'b1; #1;
        check("fetch_req",    32'(MemReq), 1);
        check("fetch_selmem", 32'(SelMEM), 1);
        check("fetch_rw",     32'(MemRW), 0);
        check("fetch_irw",    32'(IRWrite), 1);
        check("fetch_nopc",   32'(PCIncrement), 0);

        tick(); #1;
        check("addi_imm",   32'(Immediate), 'hFFFF);
        check("addi_regin", 32'(RegIn), 3);
        check("addi_rw",    32'(RegWrite), 1);
        check("addi_pcinc", 32'(PCIncrement), 1);
        check("addi_sel",   32'(SelALU), 0);
        check("addi_psrw",  32'(PSRWrite), 1);
        check("addi_op",    32'(OpCode), 5);
        check("addi_req",   32'(MemReq), 0);
        tick();

        do_fetch(16'hC0FC);
        PSR = 5'b01000; #1;
        check("bz_taken",  32'(PCBranch), 1);
        check("bz_disp",   32'(PCImmediate), 'hFFFC);
        check("bz_noinc",  32'(PCIncrement), 0);
        PSR = 5'b00000; #1;
        check("bz_nt_br",  32'(PCBranch), 0);
        check("bz_nt_inc", 32'(PCIncrement), 1);
        tick();

        do_fetch(16'h4204); #1;
        check("ld_exec_req", 32'(MemReq), 0);
        check("ld_exec_pc",  32'(PCIncrement), 0);
        MemReady = 1'b0;
        tick(); #1;
        check("ld_req",    32'(MemReq), 1);
        check("ld_selmem", 32'(SelMEM), 0);
        check("ld_regb",   32'(RegB), 4);
        check("ld_rw",     32'(MemRW), 0);
        check("ld_wait_w", 32'(RegWrite), 0);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            check("ld_hold_req", 32'(MemReq), 1);
            check("ld_hold_w",   32'(RegWrite), 0);
        end
        MemReady = 1'b1; #1;
        check("ld_done_w",   32'(RegWrite), 1);
        check("ld_done_in",  32'(RegIn), 2);
        check("ld_done_sel", 32'(SelALU), 2);
        check("ld_done_pc",  32'(PCIncrement), 1);
        tick();

        do_fetch(16'h4243);
        tick(); #1;
        check("st_rw",   32'(MemRW), 1);
        check("st_rega", 32'(RegA), 2);
        check("st_regb", 32'(RegB), 3);
        check("st_pc",   32'(PCIncrement), 1);
        check("st_w",    32'(RegWrite), 0);
        tick();

        do_fetch(16'h4EC7); #1;
        check("jmp_pcw",  32'(PCWrite), 1);
        check("jmp_regb", 32'(RegB), 7);
        check("jmp_inc",  32'(PCIncrement), 0);
        tick();

        do_fetch(16'h01B2); #1;
        check("cmp_w",    32'(RegWrite), 0);
        check("cmp_psrw", 32'(PSRWrite), 1);
        check("cmp_sel",  32'(SelALU), 1);
        check("cmp_rega", 32'(RegA), 1);
        check("cmp_regb", 32'(RegB), 2);
        tick();

        do_fetch(16'hF3AB); #1;
        check("lui_imm",  32'(Immediate), 'hAB00);
        check("lui_w",    32'(RegWrite), 1);
        check("lui_psrw", 32'(PSRWrite), 0);
        tick();

        MemReady = 1'b0;
        repeat (14) tick();
        #1;
        check("edge_fault", 32'(Fault), 0);
        check("edge_req",   32'(MemReq), 1);
        MemReady = 1'b1; INS = 16'h2000; #1;
        check("edge_ready_wins", 32'(IRWrite), 1);
        tick(); #1;
        check("ill_w",     32'(RegWrite), 0);
        check("ill_psrw",  32'(PSRWrite), 0);
        check("ill_pcinc", 32'(PCIncrement), 0);
        check("ill_pcbr",  32'(PCBranch | PCWrite), 0);
        tick(); #1;
        check("ill_fault", 32'(Fault), 1);
        check("ill_req",   32'(MemReq), 0);
        tick(); #1;
        check("ill_sticky", 32'(Fault), 1);
        Reset = 1'b0; #1;
        check("ill_rst_clr", 32'(Fault), 0);
        tick();
        Reset = 1'b1; MemReady = 1'b0;

        repeat (14) tick();
        #1;
        check("to_pre_fault", 32'(Fault), 0);
        tick(); #1;
        check("to_fault",  32'(Fault), 1);
        check("to_req",    32'(MemReq), 0);
        check("to_selmem", 32'(SelMEM), 0);
        Reset = 1'b0; #1;
        check("to_rst_clr", 32'(Fault), 0);
        tick();
        Reset = 1'b1;

        do_fetch(16'h4243);
        MemReady = 1'b0;
        tick(); #1;
        check("rmem_req", 32'(MemReq), 1);
        check("rmem_rw",  32'(MemRW), 1);
        Reset = 1'b0; #1;
        check("rmem_drop", 32'(MemReq), 0);
        check("rmem_pc",   32'(PCIncrement), 0);
        tick(); #1;
        check("rmem_hold", 32'(MemReq), 0);
        Reset = 1'b1; #1;
        check("rmem_fetch_req", 32'(MemReq), 1);
        check("rmem_fetch_sel", 32'(SelMEM), 1);
        check("rmem_fetch_pc",  32'(PCIncrement), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
